// File: rtl/receptor_solicitudes_pkg.sv
// Shared defaults and state encoding for the serial elevator-request receiver.
package receptor_solicitudes_pkg;

   localparam int unsigned NUM_PISOS_DEF = 5;
   localparam int unsigned BITS_PISO_DEF = 2;
   localparam int unsigned TIMEOUT_DEF   = 15;

   typedef enum logic {
      IDLE       = 1'b0,
      RECIBIENDO = 1'b1
   } estado_t;

endpackage

// File: rtl/receptor_solicitudes_contador.sv
// Loadable up-counter with synchronous clear; clear beats load beats increment.
module contador_bits #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/receptor_solicitudes.sv
// Assembles MSB-first serial request frames and ORs them into per-floor
// up/down request flags, with per-floor service clears.
module receptor_solicitudes
   import receptor_solicitudes_pkg::*;
#(
   parameter int unsigned NUM_PISOS = NUM_PISOS_DEF,
   parameter int unsigned BITS_PISO = BITS_PISO_DEF,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ShiftIn,
   input  logic                           ShiftEn,
   input  logic                           FrameStart,
   input  logic [NUM_PISOS-1:0]           Clear,
   output logic [NUM_PISOS*BITS_PISO-1:0] Solicitudes,
   output logic                           FrameValid,
   output logic                           FrameError,
   output logic                           Busy
);

   localparam int unsigned N  = NUM_PISOS * BITS_PISO;
   localparam int unsigned BW = $clog2(N + 1);
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   estado_t        state;
   logic [N-1:0]   frame;
   logic [N-1:0]   frameShifted;
   logic [N-1:0]   mergeFrame;
   logic [N-1:0]   clearMask;
   logic [BW-1:0]  bitCount;
   logic [IW-1:0]  idleCount;
   logic           receiving;
   logic           startBit;
   logic           dataBit;
   logic           completing;
   logic           restart;
   logic           timeoutHit;

   assign receiving    = (state == RECIBIENDO);
   assign startBit     = ShiftEn & FrameStart;
   assign dataBit      = ShiftEn & ~FrameStart & receiving;
   assign restart      = startBit & receiving;
   assign frameShifted = N'({frame, ShiftIn});
   assign mergeFrame   = startBit ? N'(ShiftIn) : frameShifted;
   assign completing   = (startBit && (N == 1)) || (dataBit && (bitCount == BW'(N - 1)));
   assign timeoutHit   = receiving & ~ShiftEn & (idleCount == IW'(TIMEOUT - 1));

   // Each Clear bit covers both request bits of its floor.
   for (genvar i = 0; i < NUM_PISOS; i++) begin : genMask
      assign clearMask[i*BITS_PISO +: BITS_PISO] = {BITS_PISO{Clear[i]}};
   end

   contador_bits #(.WIDTH(BW)) uBitCount (
      .clk       (clk),
      .reset     (reset),
      .clear     (completing | timeoutHit),
      .load      (startBit),
      .loadValue (BW'(1)),
      .enable    (dataBit),
      .count     (bitCount)
   );

   contador_bits #(.WIDTH(IW)) uIdleCount (
      .clk       (clk),
      .reset     (reset),
      .clear     (~receiving | ShiftEn | timeoutHit),
      .load      (1'b0),
      .loadValue ('0),
      .enable    (receiving & ~ShiftEn),
      .count     (idleCount)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         frame       <= '0;
         Solicitudes <= '0;
         FrameValid  <= 1'b0;
         FrameError  <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         FrameValid  <= completing;
         FrameError  <= restart | timeoutHit;
         // Clear is applied after the merge so it wins for the same floor.
         Solicitudes <= (Solicitudes | (completing ? mergeFrame : '0)) & ~clearMask;
         if (completing || timeoutHit) begin
            state <= IDLE;
            Busy  <= 1'b0;
            frame <= '0;
         end else if (startBit) begin
            state <= RECIBIENDO;
            Busy  <= 1'b1;
            frame <= N'(ShiftIn);
         end else if (dataBit) begin
            frame <= frameShifted;
         end
      end
   end

endmodule

// File: tb/tb_receptor_solicitudes.sv
// Directed bench for receptor_solicitudes with a scoreboard of expected merge results.
module tb_receptor_solicitudes;

   localparam int NP = 5;
   localparam int N  = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          ShiftIn;
   logic          ShiftEn;
   logic          FrameStart;
   logic [NP-1:0] Clear;
   logic [N-1:0]  Solicitudes;
   logic          FrameValid;
   logic          FrameError;
   logic          Busy;

   int            compared    = 0;
   int            mismatched  = 0;
   int            validPulses = 0;
   int            errorPulses = 0;
   int            errBefore;
   int            validBefore;
   logic [N-1:0]  expSol;
   logic [N-1:0]  sbQueue[$];

   always #5 clk = ~clk;

   receptor_solicitudes dut (
      .clk         (clk),
      .reset       (reset),
      .ShiftIn     (ShiftIn),
      .ShiftEn     (ShiftEn),
      .FrameStart  (FrameStart),
      .Clear       (Clear),
      .Solicitudes (Solicitudes),
      .FrameValid  (FrameValid),
      .FrameError  (FrameError),
      .Busy        (Busy)
   );

   function automatic logic [N-1:0] maskOf(input logic [NP-1:0] c);
      logic [N-1:0] m;
      for (int i = 0; i < NP; i++) m[2*i +: 2] = {2{c[i]}};
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic driveBit(input logic b, input logic fs, input logic [NP-1:0] clr);
      @(negedge clk);
      ShiftIn    = b;
      ShiftEn    = 1'b1;
      FrameStart = fs;
      Clear      = clr;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         ShiftIn    = 1'b0;
         ShiftEn    = 1'b0;
         FrameStart = 1'b0;
         Clear      = '0;
      end
   endtask

   task automatic driveClear(input logic [NP-1:0] c);
      @(negedge clk);
      ShiftEn    = 1'b0;
      FrameStart = 1'b0;
      Clear      = c;
      expSol     = expSol & ~maskOf(c);
   endtask

   // Full frame; optional Clear pulse on bit clrIdx, modelled in order.
   task automatic sendFrame(input logic [N-1:0] f, input int clrIdx, input logic [NP-1:0] clrVal);
      logic [NP-1:0] c;
      for (int i = 0; i < N; i++) begin
         c = (i == clrIdx) ? clrVal : '0;
         if (i == N - 1) begin
            expSol = (expSol | f) & ~maskOf(c);
            sbQueue.push_back(expSol);
         end else begin
            expSol = expSol & ~maskOf(c);
         end
         driveBit(f[N-1-i], (i == 0), c);
      end
   endtask

   always @(negedge clk) begin
      if (FrameValid === 1'b1) begin
         validPulses++;
         if (sbQueue.size() == 0) check("valid_unexpected", 32'(sbQueue.size()), 32'd1);
         else check("merge_result", 32'(Solicitudes), 32'(sbQueue.pop_front()));
      end
      if (FrameError === 1'b1) begin
         errorPulses++;
         check("valid_error_exclusive", 32'(FrameValid), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      ShiftIn    = 1'b0;
      ShiftEn    = 1'b0;
      FrameStart = 1'b0;
      Clear      = '0;
      expSol     = '0;
      repeat (2) @(negedge clk);
      check("reset_sol",  32'(Solicitudes), 32'd0);
      check("reset_fv",   32'(FrameValid),  32'd0);
      check("reset_fe",   32'(FrameError),  32'd0);
      check("reset_busy", 32'(Busy),        32'd0);
      reset = 1'b0;

      // Data bits without FrameStart are ignored in IDLE
      for (int i = 0; i < 3; i++) driveBit(1'b1, 1'b0, '0);
      idleCycles(1);
      check("idle_ignore_busy", 32'(Busy),        32'd0);
      check("idle_ignore_sol",  32'(Solicitudes), 32'd0);

      // Nominal frame 1000010011
      validBefore = validPulses;
      sendFrame(10'h213, -1, '0);
      idleCycles(1);
      check("nominal_sol",  32'(Solicitudes), 32'h213);
      check("nominal_fv",   32'(FrameValid),  32'd1);
      check("nominal_busy", 32'(Busy),        32'd0);
      idleCycles(1);
      check("nominal_fv_one_cycle", 32'(FrameValid), 32'd0);
      check("nominal_fv_count", 32'(validPulses - validBefore), 32'd1);

      // Accumulate, then service clear of floor 0
      sendFrame(10'h00C, -1, '0);
      idleCycles(1);
      check("accumulate_sol", 32'(Solicitudes), 32'h21F);
      driveClear(5'b00001);
      idleCycles(1);
      check("clear_floor0_sol", 32'(Solicitudes), 32'h21C);

      // Clear beats a simultaneous merge on the same floor
      driveClear(5'b11111);
      idleCycles(1);
      check("clear_all_sol", 32'(Solicitudes), 32'd0);
      sendFrame(10'h300, N - 1, 5'b10000);
      idleCycles(1);
      check("clear_priority_sol", 32'(Solicitudes), 32'h000);
      check("clear_priority_fv",  32'(FrameValid),  32'd1);

      // Restart at bit 6 aborts the partial frame
      idleCycles(1);
      errBefore = errorPulses;
      for (int i = 0; i < 6; i++) begin
         driveBit(1'b1, (i == 0), '0);
         if (i == 5) check("busy_mid_frame", 32'(Busy), 32'd1);
      end
      sendFrame(10'h001, -1, '0);
      idleCycles(1);
      check("restart_sol", 32'(Solicitudes), 32'h001);
      idleCycles(1);
      check("restart_fe_count", 32'(errorPulses - errBefore), 32'd1);

      // Idle timeout after bit 4
      errBefore = errorPulses;
      for (int i = 0; i < 4; i++) driveBit(1'b1, (i == 0), '0);
      idleCycles(15);
      check("timeout_busy_before", 32'(Busy),       32'd1);
      check("timeout_fe_before",   32'(FrameError), 32'd0);
      idleCycles(1);
      check("timeout_fe",   32'(FrameError),  32'd1);
      check("timeout_busy", 32'(Busy),        32'd0);
      check("timeout_sol",  32'(Solicitudes), 32'h001);
      idleCycles(1);
      check("timeout_fe_one_cycle", 32'(FrameError), 32'd0);
      check("timeout_fe_count", 32'(errorPulses - errBefore), 32'd1);

      // Receiver recovers; a mid-frame Clear does not disturb the frame
      sendFrame(10'h0C0, -1, '0);
      idleCycles(1);
      check("post_timeout_sol", 32'(Solicitudes), 32'h0C1);
      sendFrame(10'h00A, 4, 5'b00001);
      idleCycles(1);
      check("clear_mid_frame_sol", 32'(Solicitudes), 32'h0CA);

      // Asynchronous reset mid-frame
      idleCycles(1);
      errBefore = errorPulses;
      for (int i = 0; i < 5; i++) driveBit(1'b1, (i == 0), '0);
      @(negedge clk);
      ShiftEn    = 1'b0;
      FrameStart = 1'b0;
      reset      = 1'b1;
      expSol     = '0;
      #1;
      check("async_reset_sol",  32'(Solicitudes), 32'd0);
      check("async_reset_busy", 32'(Busy),        32'd0);
      check("async_reset_fv",   32'(FrameValid),  32'd0);
      check("async_reset_fe",   32'(FrameError),  32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idleCycles(2);
      check("reset_no_fe", 32'(errorPulses - errBefore), 32'd0);

      // First frame after reset
      validBefore = validPulses;
      sendFrame(10'h155, -1, '0);
      idleCycles(2);
      check("post_reset_sol", 32'(Solicitudes), 32'h155);
      check("post_reset_fv_count", 32'(validPulses - validBefore), 32'd1);

      check("scoreboard_empty", 32'(sbQueue.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
